// File: rtl/gf8_xpow_iter.sv
// Iterative GF(2^8) multiply-by-x^k (poly 0x11B), one xtime step per clock, valid/ready on both sides.
// Optional GF8_XPOW_DIR_EN adds in_dir to select x^-1 steps instead of x steps.
module gf8_xpow_iter #(
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [KW-1:0] in_k,
`ifdef GF8_XPOW_DIR_EN
  input  logic          in_dir,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    acc;
  logic [KW-1:0] cnt;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef GF8_XPOW_DIR_EN
  logic dir_q;

  // Inverse of xtime: rotate right, then fold x^8 back in via bits 3,2,0.
  function automatic logic [7:0] ixtime(input logic [7:0] v);
    ixtime = {v[0], v[7:1]} ^ (v[0] ? 8'h0D : 8'h00);
  endfunction

  function automatic logic [7:0] step(input logic [7:0] v, input logic d);
    step = d ? ixtime(v) : xtime(v);
  endfunction
`else
  function automatic logic [7:0] step(input logic [7:0] v);
    step = xtime(v);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (in_k != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == KW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and step counter; acc is also the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 8'h00;
      cnt   <= '0;
`ifdef GF8_XPOW_DIR_EN
      dir_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            cnt   <= in_k;
`ifdef GF8_XPOW_DIR_EN
            dir_q <= in_dir;
`endif
          end
        end
        BUSY: begin
`ifdef GF8_XPOW_DIR_EN
          acc <= step(acc, dir_q);
`else
          acc <= step(acc);
`endif
          cnt <= cnt - KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

endmodule

// File: tb/tb_gf8_xpow_iter.sv
// Self-checking bench for gf8_xpow_iter: vector table, handshake corner cases and randomized ops vs a polynomial model.
module tb_gf8_xpow_iter;

  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [KW-1:0] in_k;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          busy;
`ifdef GF8_XPOW_DIR_EN
  logic          in_dir;
`endif

  int n_pass  = 0;
  int n_total = 0;

  gf8_xpow_iter #(.KW(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
`ifdef GF8_XPOW_DIR_EN
    .in_dir(in_dir),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    int         k;
    logic [7:0] exp;
  } vec_t;

  // Polynomial model: shift a(x) by x^k as a plain integer, then long-divide by 0x11B.
  function automatic logic [7:0] model_mulx(input logic [7:0] a, input int k);
    logic [31:0] p;
    p = 32'(a) << k;
    for (int b = 30; b >= 8; b--) begin
      if (p[b]) p = p ^ (32'h11B << (b - 8));
    end
    return p[7:0];
  endfunction

  // x^-k: the unique b whose b*x^k equals a.
  function automatic logic [7:0] model_divx(input logic [7:0] a, input int k);
    for (int b = 0; b < 256; b++) begin
      if (model_mulx(8'(b), k) == a) return 8'(b);
    end
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full transaction; returns result and edges from accept to out_valid.
  task automatic run_op(input logic [7:0] a, input int k, input logic dir,
                        output logic [7:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_data  = a;
    in_k     = KW'(k);
`ifdef GF8_XPOW_DIR_EN
    in_dir   = dir;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_pop", in_ready, 1);
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] res;
    logic [7:0] held;
    logic [7:0] a;
    int         lat;
    int         k;
    logic       dir;

    tbl[0] = '{8'h57, 1,  8'hAE};
    tbl[1] = '{8'h57, 2,  8'h47};
    tbl[2] = '{8'h57, 3,  8'h8E};
    tbl[3] = '{8'h57, 4,  8'h07};
    tbl[4] = '{8'h80, 1,  8'h1B};
    tbl[5] = '{8'h3C, 0,  8'h3C};
    tbl[6] = '{8'h01, 15, 8'h2F};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_k = '0; out_ready = 1'b0;
`ifdef GF8_XPOW_DIR_EN
    in_dir = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].k, 1'b0, res, lat);
      check($sformatf("vec%0d_data", i), res, tbl[i].exp);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].k);
    end

    // Backpressure with ignored in_valid pulses during BUSY.
    in_data = 8'h57; in_k = KW'(5); in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'hFF; in_k = KW'(2);
    for (int c = 0; c < 4; c++) begin
      in_valid = c[0];
      check("bp_busy_in_ready", in_ready, 0);
      check("bp_busy_busy", busy, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_out_valid", out_valid, 1);
    held = out_data;
    check("bp_data", held, model_mulx(8'h57, 5));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, held);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Async reset in the middle of an op.
    in_data = 8'h57; in_k = KW'(8); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    run_op(8'h57, 1, 1'b0, res, lat);
    check("post_rst_data", res, 8'hAE);

`ifdef GF8_XPOW_DIR_EN
    run_op(8'h1B, 1, 1'b1, res, lat);
    check("dir_1b", res, 8'h80);
    run_op(8'hAE, 1, 1'b1, res, lat);
    check("dir_ae", res, 8'h57);
`endif

    for (int n = 0; n < 30; n++) begin
      a = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 15);
`ifdef GF8_XPOW_DIR_EN
      dir = 1'($urandom_range(0, 1));
`else
      dir = 1'b0;
`endif
      run_op(a, k, dir, res, lat);
      check("rnd_data", res, dir ? model_divx(a, k) : model_mulx(a, k));
      check("rnd_lat", lat, k);
`ifdef GF8_XPOW_DIR_EN
      if (dir) begin
        run_op(res, k, 1'b0, res, lat);
        check("rnd_roundtrip", res, a);
      end
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
